// File: rtl/param_pkg.sv
// Shared constants and the FSM state type for the memory-line arbiter.
package param_pkg;

   localparam int MAIN_MEM_LINE_AW = 8;
   localparam int BYTES_PER_LINE   = 8;
   localparam int LINE_W           = BYTES_PER_LINE * 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } iconn_mem_arb_state_t;

endpackage

// File: rtl/iconn_rr_arb.sv
// Combinational round-robin winner search: first eligible port after last_grant wins.
module iconn_rr_arb #(
   parameter int NUM_PORTS = 2,
   parameter int LGW       = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [NUM_PORTS-1:0] mask,
   input  logic [LGW-1:0]       last_grant,
   output logic [NUM_PORTS-1:0] grant
);

   logic [NUM_PORTS-1:0] eligible;
   logic                 found;
   int                   idx;

   // Walk the ports in rotating order starting just past the previous winner.
   always_comb begin
      eligible = req & mask;
      grant    = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         idx = (int'(last_grant) + i) % NUM_PORTS;
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && (j == idx) && eligible[j]) begin
               grant[j] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/iconn_mem_arb.sv
// Round-robin line arbiter in front of the main-memory controller.
// Define ICONN_MEM_ARB_WRITE_PRIO_EN to let pending writes win over reads.
module iconn_mem_arb
   import param_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic                                  clk,
   input  logic                                  resetn,
   input  logic [NUM_PORTS-1:0]                  req_valid,
   input  logic [NUM_PORTS-1:0]                  req_we,
   input  logic [NUM_PORTS*MAIN_MEM_LINE_AW-1:0] req_addr,
   input  logic [NUM_PORTS*LINE_W-1:0]           req_wdata,
   output logic [NUM_PORTS-1:0]                  req_ready,
   output logic [NUM_PORTS-1:0]                  resp_valid,
   output logic [LINE_W-1:0]                     resp_data,
   output logic [MAIN_MEM_LINE_AW-1:0]           waddr_arb2mem,
   output logic [LINE_W-1:0]                     wdata_arb2mem,
   output logic                                  wcyc_arb2mem,
   output logic [MAIN_MEM_LINE_AW-1:0]           raddr_arb2mem,
   output logic                                  rcyc_arb2mem,
   input  logic [LINE_W-1:0]                     data_mem2l,
   input  logic                                  ack_mem2arb
);

   localparam int LGW = $clog2(NUM_PORTS);

   iconn_mem_arb_state_t        state;
   logic [LGW-1:0]              last_grant;
   logic [NUM_PORTS-1:0]        cap_port;
   logic                        cap_we;
   logic [NUM_PORTS-1:0]        mask;
   logic [NUM_PORTS-1:0]        grant;
   logic [LGW-1:0]              win_idx;
   logic                        win_we;
   logic [MAIN_MEM_LINE_AW-1:0] win_addr;
   logic [LINE_W-1:0]           win_wdata;

   // With write priority, reads are masked out whenever any write is pending.
   always_comb begin
      mask = '1;
`ifdef ICONN_MEM_ARB_WRITE_PRIO_EN
      if (|(req_valid & req_we)) mask = req_we;
`endif
   end

   iconn_rr_arb #(
      .NUM_PORTS (NUM_PORTS),
      .LGW       (LGW)
   ) u_rr_arb (
      .req        (req_valid),
      .mask       (mask),
      .last_grant (last_grant),
      .grant      (grant)
   );

   always_comb begin
      win_idx   = '0;
      win_we    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (grant[j]) begin
            win_idx   = LGW'(j);
            win_we    = req_we[j];
            win_addr  = req_addr[j*MAIN_MEM_LINE_AW +: MAIN_MEM_LINE_AW];
            win_wdata = req_wdata[j*LINE_W +: LINE_W];
         end
      end
   end

   // Accept is combinational so the payload is taken in the same cycle ready is seen.
   assign req_ready = (state == IDLE && resetn) ? grant : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= IDLE;
         last_grant    <= LGW'(NUM_PORTS - 1);
         cap_port      <= '0;
         cap_we        <= 1'b0;
         resp_valid    <= '0;
         resp_data     <= '0;
         waddr_arb2mem <= '0;
         wdata_arb2mem <= '0;
         wcyc_arb2mem  <= 1'b0;
         raddr_arb2mem <= '0;
         rcyc_arb2mem  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= '0;
               if (|grant) begin
                  last_grant    <= win_idx;
                  cap_port      <= grant;
                  cap_we        <= win_we;
                  wcyc_arb2mem  <= win_we;
                  rcyc_arb2mem  <= !win_we;
                  waddr_arb2mem <= win_we ? win_addr  : '0;
                  wdata_arb2mem <= win_we ? win_wdata : '0;
                  raddr_arb2mem <= win_we ? '0 : win_addr;
                  state         <= BUSY;
               end
            end
            BUSY: begin
               if (ack_mem2arb) begin
                  wcyc_arb2mem  <= 1'b0;
                  rcyc_arb2mem  <= 1'b0;
                  waddr_arb2mem <= '0;
                  wdata_arb2mem <= '0;
                  raddr_arb2mem <= '0;
                  if (!cap_we) resp_data <= data_mem2l;
                  resp_valid    <= cap_port;
                  state         <= RESP;
               end
            end
            RESP: begin
               resp_valid <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
